// File: rtl/pc_fetch_ctrl.sv
// Program-counter and instruction-fetch controller: issues fetches at pc,
// hands fetched words to decode, and redirects through an external pc_mux.
module pc_fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc_in,
   output logic        mux_sel,
   output logic [15:0] pc_inc,
   output logic [15:0] pc,
   input  logic        branch_req,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] VALID = 2'd2;

   logic [1:0] state;
   logic       branch_pend;

   // A branch seen earlier (pending) or right now selects the target input.
   assign mux_sel     = branch_pend | branch_req;
   assign pc_inc      = pc + 16'd1;
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == VALID);

   // NOTE: state registers use non-blocking assignments so every register
   // samples the same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= 16'h0000;
         branch_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= FETCH;
            end
            FETCH: begin
               if (imem_ack) begin
                  if (mux_sel) begin
                     // Word fetched from the old path is dropped; refetch at target.
                     pc          <= pc_in;
                     branch_pend <= 1'b0;
                  end else begin
                     instr <= imem_rdata;
                     state <= VALID;
                  end
               end else if (branch_req) begin
                  branch_pend <= 1'b1;
               end
            end
            VALID: begin
               if (instr_ready) begin
                  pc          <= pc_in;
                  branch_pend <= 1'b0;
                  state       <= FETCH;
               end else if (branch_req) begin
                  branch_pend <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl: a transaction-level driver
// models the architectural PC and a separate monitor checks every handshake.
module tb_pc_fetch_ctrl;

   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc_in;
   logic        mux_sel;
   logic [15:0] pc_inc;
   logic [15:0] pc;
   logic        branch_req;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;

   logic [15:0] branch_target;
   logic [15:0] model_pc;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   pc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_in       (pc_in),
      .mux_sel     (mux_sel),
      .pc_inc      (pc_inc),
      .pc          (pc),
      .branch_req  (branch_req),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready)
   );

   // External pc_mux: in0 = sequential, in1 = branch target.
   assign pc_in = mux_sel ? branch_target : pc_inc;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] p;
      p = a * 16'h9E37;
      return p ^ 16'h5A5A;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One fetch (possibly squashed by a branch) plus, if delivered, its handshake.
   task automatic run_txn(input int t);
      int n, d, fc, h, vc;
      bit fb, vb;
      n = 0;
      while (!imem_req && n < 16) begin
         step();
         n++;
      end
      check("req_timeout", {15'd0, imem_req}, 16'd1);
      if (!imem_req) return;
      check("fetch_addr", pc, model_pc);
      check("pc_inc", pc_inc, model_pc + 16'd1);

      d  = $urandom_range(1, 3);
      fb = ($urandom_range(0, 4) == 0);
      fc = $urandom_range(0, d);
      h  = $urandom_range(0, 4);
      vb = ($urandom_range(0, 3) == 0);
      vc = $urandom_range(0, h);
      branch_target = 16'($urandom);
      if (t == 1) begin fb = 0; vb = 1; vc = h; branch_target = 16'h0040; end
      if (t == 2) begin fb = 0; vb = 0; h = 5; end
      if (t == 3) begin fb = 1; fc = 0; d = 3; branch_target = 16'h1234; end
      if (t == 4) begin fb = 1; fc = 1; d = 1; end
      if (t == 6) begin fb = 0; vb = 1; branch_target = 16'hFFFF; end
      if (t == 7) begin fb = 0; vb = 0; end

      for (int i = 0; i <= d; i++) begin
         imem_ack   = (i == d);
         imem_rdata = (i == d) ? mem_word(model_pc) : 16'hDEAD;
         branch_req = fb && (i == fc);
         #1;
         check("fetch_req_held", {15'd0, imem_req}, 16'd1);
         check("fetch_no_valid", {15'd0, instr_valid}, 16'd0);
         if (i == d) check("ack_mux_sel", {15'd0, mux_sel}, {15'd0, fb});
         step();
      end
      imem_ack   = 1'b0;
      branch_req = 1'b0;

      if (fb) begin
         model_pc = branch_target;
         return;
      end
      sb.push_back('{model_pc, mem_word(model_pc)});

      for (int i = 0; i <= h; i++) begin
         instr_ready = (i == h);
         branch_req  = vb && (i == vc);
         #1;
         check("valid_high", {15'd0, instr_valid}, 16'd1);
         check("valid_no_req", {15'd0, imem_req}, 16'd0);
         check("valid_pc", pc, model_pc);
         if (i == h) check("hs_mux_sel", {15'd0, mux_sel}, {15'd0, vb});
         step();
      end
      instr_ready = 1'b0;
      branch_req  = 1'b0;
      model_pc    = vb ? branch_target : model_pc + 16'd1;
   endtask

   // Monitor: every accepted instruction must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_instr: got %h with nothing expected at %0t", instr, $time);
            end else begin
               e = sb.pop_front();
               check("instr", instr, e.instr);
               check("hs_pc", pc, e.pc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      branch_req    = 1'b1;
      imem_ack      = 1'b0;
      imem_rdata    = 16'h0000;
      instr_ready   = 1'b0;
      branch_target = 16'h0777;
      model_pc      = RESET_PC;
      #12;
      check("rst_pc", pc, RESET_PC);
      check("rst_pc_inc", pc_inc, RESET_PC + 16'd1);
      check("rst_instr", instr, 16'h0000);
      check("rst_valid", {15'd0, instr_valid}, 16'd0);
      check("rst_req", {15'd0, imem_req}, 16'd0);
      check("rst_mux_sel_hi", {15'd0, mux_sel}, 16'd1);
      branch_req = 1'b0;
      #1;
      check("rst_mux_sel_lo", {15'd0, mux_sel}, 16'd0);

      // Release into IDLE with a branch pulse that must be ignored.
      step();
      rst_n      = 1'b1;
      branch_req = 1'b1;
      #1;
      check("idle_no_req", {15'd0, imem_req}, 16'd0);
      step();
      branch_req = 1'b0;

      for (int t = 0; t < 60; t++) run_txn(t);

      // Asynchronous reset while an instruction is held valid.
      while (!imem_req) step();
      imem_ack   = 1'b1;
      imem_rdata = mem_word(model_pc);
      step();
      imem_ack = 1'b0;
      check("pre_rst_valid", {15'd0, instr_valid}, 16'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {15'd0, instr_valid}, 16'd0);
      check("arst_req", {15'd0, imem_req}, 16'd0);
      check("arst_pc", pc, RESET_PC);
      check("arst_instr", instr, 16'h0000);
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
      step();
      rst_n = 1'b1;
      #1;
      check("rel_idle_req", {15'd0, imem_req}, 16'd0);
      step();
      imem_ack = 1'b0;
      check("rel_fetch_req", {15'd0, imem_req}, 16'd1);
      check("rel_valid", {15'd0, instr_valid}, 16'd0);
      check("rel_pc", pc, RESET_PC);
      model_pc = RESET_PC;

      for (int t = 60; t < 66; t++) run_txn(t);
      step();
      step();
      check("sb_drained", 16'(sb.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pc_in  input  16  next-PC value returned from pc_mux out.
REQ-006 mux_sel  output  1  drives pc_mux sel: 0 = sequential (in0), 1 = branch target (in1).
REQ-007 pc_inc  output  16  pc + 1, modulo 2^16, drives pc_mux in0.
REQ-008 pc  output  16  current program counter.
REQ-009 branch_req  input  1  one-cycle pulse: redirect to the target on pc_mux in1.
REQ-010 imem_req  output  1  instruction-memory read request; address is pc.
REQ-011 imem_ack  input  1  memory read complete; imem_rdata valid this cycle.
REQ-012 imem_rdata  input  16  instruction word from memory.
REQ-013 instr  output  16  fetched instruction to decode.
REQ-014 instr_valid  output  1  instr holds a valid, unsquashed instruction.
REQ-015 instr_ready  input  1  decode accepts instr this cycle.

Function
REQ-016 FSM states: IDLE, FETCH, VALID; encoding is implementation choice.
REQ-017 IDLE: one cycle after reset release, then unconditional transition to FETCH.
REQ-018 FETCH: imem_req=1, held until imem_ack; imem_req=0 in IDLE and VALID.
REQ-019 FETCH with imem_ack and no branch pending: instr <= imem_rdata, go to VALID.
REQ-020 VALID: instr_valid=1; instr and pc stable until handshake.
REQ-021 Handshake: instr_valid & instr_ready in a cycle; pc <= pc_in, go to FETCH the next cycle.
REQ-022 branch_pend register: set by branch_req in any state except IDLE; cleared when pc loads pc_in.
REQ-023 mux_sel = branch_pend | branch_req (combinational); pc_in is sampled under this select.
REQ-024 branch_req together with instr_ready in VALID: branch takes effect in that same cycle; pc <= pc_in with mux_sel=1.
REQ-025 Branch pending in FETCH at imem_ack: discard imem_rdata (instr_valid stays 0), pc <= pc_in, clear branch_pend, remain in FETCH with a new request next cycle.
REQ-026 branch_req arriving in the same cycle as imem_ack in FETCH: treated per REQ-025.
REQ-027 Branch in VALID without instr_ready: current instr stays valid; redirect on handshake.
REQ-028 Fetch latency: minimum 2 cycles from FETCH entry (1-cycle ack) to instr_valid.
REQ-029 pc_inc wraps: pc=16'hFFFF gives pc_inc=16'h0000; no overflow flag.
REQ-030 branch_req in IDLE is ignored.
REQ-031 pc changes only on reset, on handshake (REQ-021), or on branch discard (REQ-025).

Reset
REQ-032 Reset values: pc=RESET_PC, pc_inc=RESET_PC+1, state=IDLE, instr=16'h0000, instr_valid=0, imem_req=0, branch_pend=0, mux_sel=branch_req.
REQ-033 Reset asserted mid-fetch or while VALID: outputs take reset values immediately, without waiting for clk; any outstanding imem_ack after release is ignored until FETCH.

Verification
REQ-034 Reset release, imem_ack 1 cycle after each req, instr_ready=1, mux returns pc_inc -> fetch addresses 0x0000, 0x0001, 0x0002; instr_valid every 3rd cycle.
REQ-035 instr_ready=0 for 5 cycles in VALID -> instr, pc stable, imem_req=0; on ready, pc advances by exactly 1.
REQ-036 Pulse branch_req in VALID with instr_ready=1, mux in1=0x0040 -> mux_sel=1 that cycle, next fetch address 0x0040.
REQ-037 Pulse branch_req during FETCH (ack 3 cycles later), in1=0x1234 -> fetched word discarded, instr_valid never rises for it, next request at 0x1234.
REQ-038 pc=0xFFFF, handshake with sequential select -> pc_inc=0x0000 before, pc=0x0000 after.
REQ-039 Assert rst_n low between clock edges while in VALID -> instr_valid, imem_req drop asynchronously, pc=RESET_PC; after release IDLE then FETCH at RESET_PC.
